// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared LSU op encodings, state enum and constants
package ysyx_25020047_pkg;

  typedef enum logic [1:0] {
    OP_LW  = 2'b00,
    OP_LBU = 2'b01,
    OP_SW  = 2'b10,
    OP_SB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Stores are the ops with the top encoding bit set.
  function automatic logic is_store(input op_e op);
    return op[1];
  endfunction

  // Only word ops carry an alignment constraint; byte ops are always legal.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
    return ((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_lane.sv
// rtl/ysyx_25020047_lsu_lane.sv - byte-lane mask, store replication and load extraction
module ysyx_25020047_lsu_lane
  import ysyx_25020047_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  // Byte stores replicate the low byte so any lane selected by the mask sees it.
  always_comb begin
    wmask_o     = 4'b0000;
    wdata_o     = wdata_i;
    load_data_o = rdata_i;
    case (op_i)
      OP_SW:  wmask_o = 4'hF;
      OP_SB: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      OP_LBU: load_data_o = {24'b0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// rtl/ysyx_25020047_lsu_ctrl.sv - multi-cycle load/store sequencer with response watchdog
module ysyx_25020047_lsu_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        err,
  output logic        busy
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic [31:0] lane_load;

  ysyx_25020047_lsu_lane u_lane (
    .op_i        (op_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .wmask_o     (mem_wmask),
    .wdata_o     (mem_wdata),
    .load_data_o (lane_load)
  );

  // State, watchdog counter and captured op; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      op_q      <= OP_LW;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      err_q     <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Next-state: accept in IDLE, wait for ack or watchdog in REQ, one pulse in RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          op_d    = op_e'(ex_op);
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          rd_d    = ex_rd;
          cnt_d   = 8'd0;
          if (is_misaligned(op_e'(ex_op), ex_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the final allowed cycle is checked first, so it beats the watchdog.
        if (mem_ack) begin
          if (!is_store(op_q)) begin
            wb_rd_d   = rd_q;
            wb_data_d = lane_load;
          end
          cnt_d   = 8'd0;
          state_d = S_RESP;
        end else if (cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        err_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ex_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign mem_req  = (state_q == S_REQ);
  assign mem_we   = is_store(op_q);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_valid = (state_q == S_RESP) && !err_q && !is_store(op_q);
  assign st_done  = (state_q == S_RESP) && !err_q && is_store(op_q);
  assign err      = (state_q == S_RESP) && err_q;

endmodule

// File: doc/ysyx_25020047_lsu_ctrl.md
# ysyx_25020047_lsu_ctrl

Multi-cycle load/store sequencer between the EXU and the data-memory port. Accepts one memory op (lw, lbu, sw, sb) per handshake from the EXU, with the EXU sum rdata1+imm as the address. Drives a req/ack memory interface with byte-lane masks and a response watchdog. Returns either a register-writeback pulse or a store-done pulse, with an error pulse on misalignment or timeout.

## Interface
- TIMEOUT, 255: max cycles mem_req may stay high without mem_ack; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EXU presents a memory op.
- ex_ready  out  1  LSU accepts the op this cycle; high only in IDLE.
- ex_op  in  2  00 lw, 01 lbu, 10 sw, 11 sb.
- ex_addr  in  32  effective address.
- ex_wdata  in  32  store data (rs2).
- ex_rd  in  5  load destination register.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned store data.
- mem_wmask  out  4  byte enables; 0 for reads.
- mem_ack  in  1  completes the request in the same cycle; rdata valid with it.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  5  destination register, valid with wb_valid.
- wb_data  out  32  load result, valid with wb_valid.
- st_done  out  1  one-cycle pulse: store completed.
- err  out  1  one-cycle pulse: misaligned or timed-out op; no writeback.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: ex_ready=1. On ex_valid, latch op, addr, wdata, rd.
  - Misaligned op: lw or sw with addr[1:0]!=0. Go to RESP with err flag set; no memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1. Address, wdata, wmask and we come from registered values and stay stable for the whole request.
  - On mem_ack: capture mem_rdata and go to RESP.
  - Otherwise increment the 8-bit wait counter. When the counter reaches TIMEOUT-1 with no ack, drop the request and go to RESP with err.
- RESP: emit exactly one pulse, then return to IDLE.
  - Error case: err.
  - Load: wb_valid.
  - Store: st_done.
- Lane rules:
  - sw: wmask=4'hF; wdata passes through unchanged.
  - sb: wmask=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - lw: wb_data=rdata.
  - lbu: wb_data={24'b0, rdata byte addr[1:0]}, i.e. rdata[8*addr[1:0]+:8].
- mem_ack outside REQ is ignored.

## Timing
- Reset (async assert): state IDLE; counter 0.
  - All outputs 0 except ex_ready=1.
  - mem_req drops immediately, including mid-request. The in-flight op is discarded with no pulse.
- Handshake occurs in cycle T (ex_valid & ex_ready).
  - mem_req rises in T+1.
  - With ack in T+1, the pulse appears in T+2. Minimum accept-to-writeback latency is 2 cycles.
  - With ack in T+k, the pulse appears in T+k+1.
- Misaligned op accepted in T: err in T+1; mem_req never asserts.
- Timeout: mem_req is high for exactly TIMEOUT cycles (T+1..T+TIMEOUT) and err pulses in T+TIMEOUT+1.
  - If ack arrives in the final allowed cycle, ack wins and there is no err.
- Throughput: at most one op per 3 cycles. ex_ready is low during REQ and RESP.
- Output timing:
  - wb_rd/wb_data are registered; they hold their last values and are meaningful only with wb_valid.
  - Pulses are mutually exclusive and never repeat.

## Structure
- Shared package ysyx_25020047_pkg:
  - op encodings (OP_LW, OP_LBU, OP_SW, OP_SB);
  - lsu state enum;
  - default TIMEOUT constant.
- One natural sub-module, ysyx_25020047_lsu_lane: combinational mask/wdata replication and lbu byte extraction, shared with future lh/lhu/sh support.
- FSM, counter and capture registers stay in the top.

## Test plan
- lw addr 0x80000004, ack in cycle after req, rdata 0xDEADBEEF:
  - mem_addr=0x80000004, we=0, wmask=0;
  - wb_valid at T+2 with wb_data=0xDEADBEEF and wb_rd as latched.
- lbu addr 0x80000003, rdata 0x11223344:
  - mem_addr=0x80000000;
  - wb_data=0x00000011.
- sb addr 0x80000002, wdata 0x000000AB, ack after 3 waits:
  - wmask=4'b0100 and mem_wdata=0xABABABAB, stable during all 4 req cycles;
  - st_done once.
- sw addr 0x80000006: err at T+1; mem_req never high; no st_done.
- TIMEOUT=4, lw with no ack: mem_req high 4 cycles, then err; a new op is accepted the cycle after.
- rst_n low while in REQ: mem_req low immediately; after release, ex_ready=1 and no pulse from the aborted op.
